// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access unit: mem_op bit positions,
// FSM state codes, bus size codes and a byte-lane mask helper.
package mem_access_pkg;

    localparam int OP_SW  = 0;
    localparam int OP_SH  = 1;
    localparam int OP_SB  = 2;
    localparam int OP_LW  = 3;
    localparam int OP_LHU = 4;
    localparam int OP_LH  = 5;
    localparam int OP_LBU = 6;
    localparam int OP_LB  = 7;
    localparam int OP_SWR = 8;
    localparam int OP_SWL = 9;
    localparam int OP_LWR = 10;
    localparam int OP_LWL = 11;

    localparam logic [11:0] OP_LOAD_MASK    = 12'hCF8;
    localparam logic [11:0] OP_STORE_MASK   = 12'h307;
    localparam logic [11:0] OP_UNALIGN_MASK = 12'hF00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Mask covering the lowest nbytes byte lanes of a word.
    function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
        case (nbytes)
            3'd0:    return 32'h0000_0000;
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            3'd3:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// SRAM-like data bus between the MEM stage (master) and the AXI4 bridge (slave).
interface mem_access_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: access size, store strobes/data and load
// extraction/extension/merge for the unaligned-word loads.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [11:0] mem_op,
    input  logic [1:0]  a,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [4:0]  lsh_s;
    logic [4:0]  rsh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // lsh_s = 8*a, rsh_s = 8*(3-a)
    assign lsh_s  = {a, 3'b000};
    assign rsh_s  = {2'd3 - a, 3'b000};
    assign byte_s = rdata[lsh_s +: 8];
    assign half_s = a[1] ? rdata[31:16] : rdata[15:0];

    // Access size and store-side lane shaping.
    always_comb begin
        size  = SIZE_BYTE;
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
        case (1'b1)
            mem_op[OP_SW]: begin
                size  = SIZE_WORD;
                wstrb = 4'b1111;
                wdata = rt;
            end
            mem_op[OP_SH]: begin
                size  = SIZE_HALF;
                wstrb = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rt[15:0]}};
            end
            mem_op[OP_SB]: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << a;
                wdata = {4{rt[7:0]}};
            end
            mem_op[OP_SWL]: begin
                size  = SIZE_WORD;
                wstrb = 4'b1111 >> (2'd3 - a);
                wdata = rt >> rsh_s;
            end
            mem_op[OP_SWR]: begin
                size  = SIZE_WORD;
                wstrb = 4'b1111 << a;
                wdata = rt << lsh_s;
            end
            mem_op[OP_LW], mem_op[OP_LWL], mem_op[OP_LWR]: size = SIZE_WORD;
            mem_op[OP_LH], mem_op[OP_LHU]:                 size = SIZE_HALF;
            default:                                       size = SIZE_BYTE;
        endcase
    end

    // Load formatting; lwl/lwr keep the rt bytes the bus word does not cover.
    always_comb begin
        load_data = rdata;
        case (1'b1)
            mem_op[OP_LB]:  load_data = {{24{byte_s[7]}}, byte_s};
            mem_op[OP_LBU]: load_data = {24'h00_0000, byte_s};
            mem_op[OP_LH]:  load_data = {{16{half_s[15]}}, half_s};
            mem_op[OP_LHU]: load_data = {16'h0000, half_s};
            mem_op[OP_LWL]: load_data = (rdata << rsh_s) | (rt & byte_mask(3'd3 - {1'b0, a}));
            mem_op[OP_LWR]: load_data = (rdata >> lsh_s) | (rt & ~byte_mask(3'd4 - {1'b0, a}));
            default:        load_data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// MEM-stage access unit: captures one EX result, runs the bus transaction
// for memory ops and holds a registered writeback result for WB.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [11:0] in_mem_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_rt,
    input  logic        in_rf_we,
    input  logic [4:0]  in_rf_waddr,
    input  logic        in_except,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_rf_we,
    output logic [4:0]  out_rf_waddr,
    output logic [31:0] out_rf_wdata,
    mem_access_if.master bus,
    output logic        stall_req
);
    logic [1:0]  state_r, next_state_s, accept_tgt_s;
    logic        discard_r, discard_nxt_s;
    logic [31:0] pc_r, addr_r, rt_r, wdata_r;
    logic [11:0] mem_op_r;
    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic        accept_s, latch_load_s;
    logic [31:0] load_data_s;

    // Nothing is accepted during reset or a flush cycle.
    assign in_ready     = rst & ~flush & ((state_r == ST_IDLE) | ((state_r == ST_HOLD) & out_ready));
    assign accept_s     = in_valid & in_ready;
    assign accept_tgt_s = ((|in_mem_op) & ~in_except) ? ST_ADDR : ST_HOLD;

    // Next-state, discard tracking and load-latch decision.
    always_comb begin
        next_state_s  = state_r;
        discard_nxt_s = discard_r;
        latch_load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = accept_tgt_s;
                else          next_state_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (bus.data_addr_ok) begin
                    next_state_s  = ST_DATA;
                    discard_nxt_s = flush;
                end else if (flush) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus.data_data_ok) begin
                    discard_nxt_s = 1'b0;
                    if (discard_r | flush) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_HOLD;
                        latch_load_s = |(mem_op_r & OP_LOAD_MASK);
                    end
                end else if (flush) begin
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_r;
                end
            end
            ST_HOLD: begin
                if (flush)          next_state_s = ST_IDLE;
                else if (accept_s)  next_state_s = accept_tgt_s;
                else if (out_ready) next_state_s = ST_IDLE;
                else                next_state_s = ST_HOLD;
            end
            default: begin
                next_state_s  = ST_IDLE;
                discard_nxt_s = 1'b0;
            end
        endcase
    end

    // State and captured-operation registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            discard_r  <= 1'b0;
            pc_r       <= 32'h0000_0000;
            mem_op_r   <= 12'h000;
            addr_r     <= 32'h0000_0000;
            rt_r       <= 32'h0000_0000;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            wdata_r    <= 32'h0000_0000;
        end else begin
            state_r   <= next_state_s;
            discard_r <= discard_nxt_s;
            if (accept_s) begin
                pc_r       <= in_pc;
                mem_op_r   <= in_mem_op;
                addr_r     <= in_addr;
                rt_r       <= in_rt;
                rf_we_r    <= in_rf_we & ~in_except;
                rf_waddr_r <= in_rf_waddr;
                wdata_r    <= in_addr;
            end else if (latch_load_s) begin
                wdata_r <= load_data_s;
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    mem_align u_align (
        .mem_op    (mem_op_r),
        .a         (addr_r[1:0]),
        .rt        (rt_r),
        .rdata     (bus.data_rdata),
        .size      (bus.data_size),
        .wstrb     (bus.data_wstrb),
        .wdata     (bus.data_wdata),
        .load_data (load_data_s)
    );

    assign bus.data_req  = (state_r == ST_ADDR);
    assign bus.data_wr   = |(mem_op_r & OP_STORE_MASK);
    assign bus.data_addr = (|(mem_op_r & OP_UNALIGN_MASK)) ? {addr_r[31:2], 2'b00} : addr_r;
    assign stall_req     = (state_r == ST_ADDR) | (state_r == ST_DATA);
    assign out_valid     = (state_r == ST_HOLD);
    assign out_pc        = pc_r;
    assign out_rf_we     = rf_we_r;
    assign out_rf_waddr  = rf_waddr_r;
    assign out_rf_wdata  = wdata_r;
endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized bench for mem_access with a byte-lane reference model.
module tb_mem_access;
    localparam logic [11:0] LWL = 12'h800, LWR = 12'h400, SWL = 12'h200, SWR = 12'h100;
    localparam logic [11:0] LB  = 12'h080, LBU = 12'h040, LH  = 12'h020, LHU = 12'h010;
    localparam logic [11:0] LW  = 12'h008, SB  = 12'h004, SH  = 12'h002, SW  = 12'h001;

    logic        clk, rst;
    logic        in_valid, in_ready, in_rf_we, in_except, flush;
    logic [31:0] in_pc, in_addr, in_rt;
    logic [11:0] in_mem_op;
    logic [4:0]  in_rf_waddr;
    logic        out_valid, out_ready, out_rf_we, stall_req;
    logic [31:0] out_pc, out_rf_wdata;
    logic [4:0]  out_rf_waddr;
    int          total = 0;
    int          bad = 0;

    mem_access_if bus ();

    mem_access dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_mem_op(in_mem_op),
        .in_addr(in_addr), .in_rt(in_rt), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_except(in_except), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rf_we(out_rf_we),
        .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
        .bus(bus), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_store(input logic [11:0] op);
        return op inside {SB, SH, SW, SWL, SWR};
    endfunction

    function automatic logic [1:0] m_size(input logic [11:0] op);
        if (op inside {LW, SW, LWL, LWR, SWL, SWR}) return 2'd2;
        if (op inside {LH, LHU, SH}) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [11:0] op, input logic [31:0] addr);
        if (op inside {LWL, LWR, SWL, SWR}) return addr & ~32'd3;
        return addr;
    endfunction

    // Which memory byte lanes a store writes.
    function automatic logic [3:0] m_strb(input logic [11:0] op, input int a);
        logic [3:0] s;
        s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            case (op)
                SB:      s[i] = (i == a);
                SH:      s[i] = ((i / 2) == (a / 2));
                SW:      s[i] = 1'b1;
                SWL:     s[i] = (i <= a);
                SWR:     s[i] = (i >= a);
                default: s[i] = 1'b0;
            endcase
        end
        return s;
    endfunction

    // Bus write data, lane by lane: which rt byte lands in each lane.
    function automatic logic [31:0] m_wdata(input logic [11:0] op, input int a, input logic [31:0] rt);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            case (op)
                SB:      w[8*i +: 8] = rt[7:0];
                SH:      w[8*i +: 8] = rt[8*(i%2) +: 8];
                SW:      w[8*i +: 8] = rt[8*i +: 8];
                SWL:     w[8*i +: 8] = (i <= a) ? rt[8*(i+3-a) +: 8] : 8'h00;
                SWR:     w[8*i +: 8] = (i >= a) ? rt[8*(i-a) +: 8] : 8'h00;
                default: w[8*i +: 8] = 8'h00;
            endcase
        end
        return w;
    endfunction

    // Writeback value: loaded/merged word for loads, else the ALU result.
    function automatic logic [31:0] m_result(input logic [11:0] op, input logic [31:0] addr,
                                             input logic [31:0] rt, input logic [31:0] rd, input logic exc);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        a = int'(addr[1:0]);
        b = rd[8*a +: 8];
        h = rd[16*(a/2) +: 16];
        r = rt;
        if (exc) return addr;
        case (op)
            LB:  return {{24{b[7]}}, b};
            LBU: return {24'd0, b};
            LH:  return {{16{h[15]}}, h};
            LHU: return {16'd0, h};
            LW:  return rd;
            LWL: begin
                for (int j = 0; j < 4; j++)
                    if (j >= 3 - a) r[8*j +: 8] = rd[8*(j-3+a) +: 8];
                return r;
            end
            LWR: begin
                for (int j = 0; j < 4; j++)
                    if (j <= 3 - a) r[8*j +: 8] = rd[8*(j+a) +: 8];
                return r;
            end
            default: return addr;
        endcase
    endfunction

    task automatic rst_checks(input string pfx);
        chk({pfx, "_ctrl"}, {in_ready, out_valid, bus.data_req, stall_req, bus.data_wr, out_rf_we}, 6'd0);
        chk({pfx, "_pc"}, out_pc, 32'd0);
        chk({pfx, "_wdata"}, out_rf_wdata, 32'd0);
        chk({pfx, "_bus"}, {bus.data_addr, bus.data_wdata}, 64'd0);
        chk({pfx, "_misc"}, {bus.data_size, bus.data_wstrb, out_rf_waddr}, 11'd0);
    endtask

    task automatic drive_in(input logic [11:0] op, input logic [31:0] addr, input logic [31:0] rt,
                            input logic exc, input logic we, input logic [4:0] wa, input logic [31:0] pc);
        in_valid = 1'b1; in_pc = pc; in_mem_op = op; in_addr = addr; in_rt = rt;
        in_except = exc; in_rf_we = we; in_rf_waddr = wa;
    endtask

    // One full operation starting at a negedge where the unit can accept.
    task automatic do_op(input logic [11:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rd, input logic exc, input logic we, input logic [4:0] wa,
                         input int ad, input int dd, input int hold);
        logic [31:0] pc;
        int a;
        pc = $urandom;
        a = int'(addr[1:0]);
        drive_in(op, addr, rt, exc, we, wa, pc);
        out_ready = 1'b1;
        #1 chk("accept_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (op != 12'd0 && !exc) begin
            chk("req_fields", {bus.data_req, stall_req, bus.data_wr, bus.data_size},
                {1'b1, 1'b1, is_store(op), m_size(op)});
            chk("req_addr", bus.data_addr, m_addr(op, addr));
            if (is_store(op))
                chk("req_store", {bus.data_wstrb, bus.data_wdata}, {m_strb(op, a), m_wdata(op, a, rt)});
            for (int i = 0; i < ad; i++) begin
                @(negedge clk);
                #1 chk("req_held", {bus.data_req, stall_req, bus.data_addr}, {2'b11, m_addr(op, addr)});
            end
            bus.data_addr_ok = 1'b1;
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            #1 chk("req_drop", {out_valid, bus.data_req, stall_req}, 3'b001);
            for (int i = 0; i < dd; i++) begin
                @(negedge clk);
                #1 chk("data_wait", {out_valid, bus.data_req, stall_req}, 3'b001);
            end
            bus.data_data_ok = 1'b1;
            bus.data_rdata = rd;
            @(negedge clk);
            bus.data_data_ok = 1'b0;
            bus.data_rdata = $urandom;
            #1;
        end else begin
            chk("no_req", {bus.data_req, stall_req}, 2'b00);
        end
        chk("result", {out_valid, out_rf_we, out_rf_waddr, out_pc}, {1'b1, we & ~exc, wa, pc});
        chk("wdata", out_rf_wdata, m_result(op, addr, rt, rd, exc));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            #1 chk("hold", {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_pc = 32'd0; in_mem_op = 12'd0; in_addr = 32'd0; in_rt = 32'd0;
        in_rf_we = 1'b0; in_rf_waddr = 5'd0; in_except = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1 rst_checks("reset");
        rst = 1'b1;
        @(negedge clk);

        // Directed sequence, back-to-back through HOLD.
        do_op(12'd0, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 0, 0, 0);
        do_op(LB,  32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1'b0, 1'b1, 5'd7, 2, 2, 0);
        do_op(SB,  32'h0000_2002, 32'hAABB_CCDD, 32'd0, 1'b0, 1'b0, 5'd0, 0, 0, 0);
        do_op(SWR, 32'h0000_2001, 32'hAABB_CCDD, 32'd0, 1'b0, 1'b0, 5'd0, 0, 0, 1);
        do_op(LWL, 32'h0000_3001, 32'h1122_3344, 32'hA1B2_C3D4, 1'b0, 1'b1, 5'd9, 0, 0, 0);
        do_op(LWR, 32'h0000_3002, 32'h1122_3344, 32'hA1B2_C3D4, 1'b0, 1'b1, 5'd10, 1, 0, 0);
        do_op(LW,  32'h0000_4002, 32'd0, 32'd0, 1'b1, 1'b1, 5'd3, 0, 0, 0);
        @(negedge clk);

        // Flush while in DATA: late response must be swallowed.
        drive_in(LW, 32'h0000_5000, 32'd0, 1'b0, 1'b1, 5'd4, 32'h0000_0100);
        @(negedge clk);
        in_valid = 1'b0;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        flush = 1'b1;
        #1 chk("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_data_wait", {stall_req, out_valid}, 2'b10);
        @(negedge clk);
        bus.data_data_ok = 1'b1;
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        #1 chk("flush_data_idle", {out_valid, stall_req, in_ready}, 3'b001);
        @(negedge clk);
        #1 chk("flush_data_noout", out_valid, 1'b0);

        // Flush in ADDR without addr_ok withdraws the request.
        drive_in(SW, 32'h0000_6000, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'h0000_0200);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1 chk("flush_addr_req", bus.data_req, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_addr_drop", {bus.data_req, stall_req, out_valid, in_ready}, 4'b0001);

        // Reset in the middle of DATA.
        @(negedge clk);
        drive_in(LW, 32'h0000_7000, 32'd0, 1'b0, 1'b1, 5'd8, 32'h0000_0300);
        @(negedge clk);
        in_valid = 1'b0;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        rst = 1'b0;
        #1 rst_checks("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized operations with random bus and WB backpressure.
        for (int n = 0; n < 60; n++) begin
            int k;
            logic [11:0] op;
            logic [31:0] ad;
            logic exc;
            k = $urandom_range(0, 12);
            op = (k == 12) ? 12'd0 : (12'd1 << k);
            ad = $urandom;
            exc = ($urandom_range(0, 9) == 0);
            if (!exc) begin
                if (op == LW || op == SW) ad[1:0] = 2'b00;
                else if (op == LH || op == LHU || op == SH) ad[0] = 1'b0;
            end
            do_op(op, ad, $urandom, $urandom, exc, 1'($urandom), 5'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage memory access unit, directly downstream of the EX stage.
- Takes one decoded memory operation per handshake: address, store data, mem_op one-hot, writeback info.
- Drives the SRAM-like data interface to the AXI4 bridge (req/addr_ok/data_ok), then aligns, extends and merges load data.
- Presents a registered writeback result to the WB register. Stalls upstream while a bus transaction is outstanding.

Parameters:
- none; all widths fixed by the MIPS32 datapath.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX result valid
- in_ready  out  1  unit can accept; = (state==IDLE) | (state==HOLD & out_ready)
- in_pc  in  32  instruction PC
- in_mem_op  in  12  one-hot {lwl,lwr,swl,swr,lb,lbu,lh,lhu,lw,sb,sh,sw}; all-zero = no memory access
- in_addr  in  32  effective address / ALU result
- in_rt  in  32  rt value: store data and lwl/lwr merge source
- in_rf_we  in  1  register write enable
- in_rf_waddr  in  5  destination register
- in_except  in  1  exception already flagged upstream; suppresses bus access
- flush  in  1  exception/eret flush from CP0
- out_valid  out  1  writeback result valid
- out_ready  in  1  WB accepts
- out_pc  out  32  PC
- out_rf_we  out  1  write enable; forced 0 if in_except
- out_rf_waddr  out  5  destination
- out_rf_wdata  out  32  load result, or in_addr for non-load
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wstrb  out  4  byte strobes
- data_wdata  out  32  store data, lane-replicated
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response done; rdata valid
- data_rdata  in  32  read data
- stall_req  out  1  state==ADDR or DATA

Behaviour:
- Reset (rst=0, async): state=IDLE, discard=0. All registered fields and all outputs are 0.
- Accept (in_valid & in_ready): capture all in_* fields into registers.
  - Memory op and !in_except: go to ADDR.
  - Otherwise: go to HOLD.
- IDLE: out_valid=0, data_req=0.
- ADDR: data_req=1; request fields are driven from the registers and held stable.
  - addr_ok=1: go to DATA.
- DATA: data_req=0.
  - data_ok=1 with discard=0: format rdata, latch out_rf_wdata, go to HOLD.
  - data_ok=1 with discard=1: clear discard, go to IDLE.
- HOLD: out_valid=1.
  - out_ready=1: go to IDLE, or back-to-back accept of a new op in the same cycle.
- Minimum latencies:
  - Non-memory op: 1 cycle, accept to out_valid.
  - Memory op: 3 cycles with addr_ok and data_ok each asserted on the first possible cycle.
- Flush:
  - IDLE / HOLD: go to IDLE, out_valid drops next cycle.
  - ADDR with addr_ok=0: go to IDLE; the request is withdrawn.
  - ADDR with addr_ok=1: go to DATA with discard=1.
  - DATA: discard=1; the response is still awaited before returning to IDLE.
  - While flush=1, in_ready=0.
- data_ok arriving in the same cycle as addr_ok is not supported; the bridge guarantees at least 1 cycle between them.
- Request encoding:
  - lw/sw: size 2.
  - lh/lhu/sh: size 1.
  - lb/lbu/sb: size 0.
  - lwl/lwr/swl/swr: size 2, addr = {addr[31:2],2'b00}.
  - Other ops: addr passes through unchanged.
- Store strobes, with a = addr[1:0]:
  - sb: 0001<<a.
  - sh: a[1] ? 1100 : 0011.
  - sw: 1111.
  - swl, a=0..3: 0001, 0011, 0111, 1111.
  - swr, a=0..3: 1111, 1110, 1100, 1000.
- Store data:
  - sb: byte replicated x4.
  - sh: half replicated x2.
  - swl: rt >> 8*(3-a).
  - swr: rt << 8*a.
- Load data:
  - lb/lbu: byte a, sign-extended / zero-extended.
  - lh/lhu: half a[1], sign-extended / zero-extended.
  - lw: rdata.
  - lwl, a=0..3: {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
  - lwr, a=0..3: rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
- Misaligned lw/lh/sw/sh never reach the bus: upstream raises in_except.

Decomposition:
- Shared defines header holds:
  - mem_op bit indices;
  - FSM state encodings IDLE=0, ADDR=1, DATA=2, HOLD=3;
  - size codes.
- One combinational sub-module, mem_align, holds strobe, store-data and load-format logic (inputs: mem_op, a, rt, rdata).
- The FSM and registers stay in mem_access.

Test Plan:
- Non-memory op: in_addr=0x1234, rf_we=1, waddr=5, out_ready=1 -> out_valid the next cycle, wdata=0x00001234, data_req never asserted.
- lb: addr 0x1003, rdata 0x80FF_FF7F, addr_ok/data_ok delayed 2 cycles each -> data_size=0, wdata=0x0000_0080 sign-extended to 0xFFFF_FF80; stall_req high throughout ADDR/DATA.
- sb then swr, rt=0xAABB_CCDD:
  - sb, addr 0x2002 -> strobe 0100, data 0xDDDD_DDDD.
  - swr, addr 0x2001 -> addr 0x2000, strobe 1110, data 0xBBCC_DD00.
- lwl, addr 0x3001, rt=0x1122_3344, rdata=0xA1B2_C3D4 -> result 0xC3D4_3344; back-to-back accept with out_ready=1 on the HOLD cycle incurs no bubble.
- Flush while in DATA -> data_ok 2 cycles later produces no out_valid, state IDLE. Flush in ADDR with addr_ok=0 -> data_req drops the next cycle.
- in_except=1 with a lw op -> no data_req, out_valid after 1 cycle, out_rf_we=0. rst asserted mid-DATA -> all outputs 0 immediately.
